mem_port_arbiter: RTL and testbench

//  - Shares one single-port unified instruction/data memory between instruction fetch (IF) and load/store (LS).
//  - Sits between the pipeline stages and the memory macro.
//  - Grants one access at a time, sequences the fixed memory wait states and returns read data with a valid pulse.
//  - While IF is not granted, the fetch stage holds off; the stall/flush controller sees busy_o.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_wait_timer.sv | 32 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter:
// FSM state encodings, requester IDs and default timing parameters.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_ACC = 2'd1,
        ARB_LS_ACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam int unsigned WAIT_CYC_DEF   = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Memory wait-state timer: loaded with WAIT_CYC on a grant edge, counts
// down once per edge and stops at zero. done is high while the count is 1,
// i.e. during the cycle whose closing edge captures the read data.
import mem_port_arbiter_pkg::*;

module arb_wait_timer #(
    parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic clk_cpu_n,
    input  logic rst_n_i,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(WAIT_CYC + 1);

    logic [CW-1:0] cnt;

    // Load on grant, otherwise decrement towards zero without wrapping.
    always_ff @(posedge clk_cpu_n or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port instruction/data memory between the
// instruction fetch (IF) and load/store (LS) stages. One access at a time,
// LS has priority; read data returns WAIT_CYC edges after the grant edge.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive LS
// grants taken while IF was waiting, the next IDLE decision goes to IF.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int unsigned WAIT_CYC   = WAIT_CYC_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk_cpu_n,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    arb_state_t  state, state_nxt;
    req_id_t     pick;
    logic        grant_if, grant_ls, if_first, tmr_done;
    logic        acc_store, acc_store_nxt;
    logic        if_gnt_nxt, ls_gnt_nxt, if_rvalid_nxt, ls_rvalid_nxt, mem_en_nxt;
    logic [3:0]  mem_we_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt, if_rdata_nxt, ls_rdata_nxt;

    arb_wait_timer #(.WAIT_CYC(WAIT_CYC)) u_wait_timer (
        .clk_cpu_n (clk_cpu_n),
        .rst_n_i   (rst_n_i),
        .load      (grant_if | grant_ls),
        .done      (tmr_done)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    // Count LS grants that overtook a waiting IF; cleared by an IF grant or an idle IF.
    always_ff @(posedge clk_cpu_n or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (!if_req_i || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_ls && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign if_first = if_req_i && (starve_cnt == SW'(STARVE_MAX));
`else
    assign if_first = 1'b0;
`endif

    // Next-state and next-output decode; memory controls hold unless a new grant reloads them.
    always_comb begin
        state_nxt     = state;
        pick          = REQ_LS;
        grant_if      = 1'b0;
        grant_ls      = 1'b0;
        acc_store_nxt = acc_store;
        if_gnt_nxt    = 1'b0;
        ls_gnt_nxt    = 1'b0;
        if_rvalid_nxt = 1'b0;
        ls_rvalid_nxt = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = mem_we_o;
        mem_addr_nxt  = mem_addr_o;
        mem_wdata_nxt = mem_wdata_o;
        if_rdata_nxt  = if_rdata_o;
        ls_rdata_nxt  = ls_rdata_o;
        case (state)
            ARB_IDLE: begin
                if (if_first || (if_req_i && !ls_req_i)) begin
                    pick = REQ_IF;
                end
                if ((ls_req_i && pick == REQ_LS) || (if_req_i && pick == REQ_IF)) begin
                    mem_en_nxt = 1'b1;
                    if (pick == REQ_LS) begin
                        grant_ls      = 1'b1;
                        ls_gnt_nxt    = 1'b1;
                        acc_store_nxt = ls_we_i;
                        mem_we_nxt    = ls_we_i ? ls_be_i : 4'b0000;
                        mem_addr_nxt  = ls_addr_i;
                        mem_wdata_nxt = ls_wdata_i;
                        state_nxt     = ARB_LS_ACC;
                    end else begin
                        grant_if      = 1'b1;
                        if_gnt_nxt    = 1'b1;
                        mem_we_nxt    = 4'b0000;
                        mem_addr_nxt  = if_addr_i;
                        state_nxt     = ARB_IF_ACC;
                    end
                end
            end
            ARB_IF_ACC: begin
                if (tmr_done) begin
                    if_rdata_nxt  = mem_rdata_i;
                    if_rvalid_nxt = 1'b1;
                    state_nxt     = ARB_IDLE;
                end
            end
            ARB_LS_ACC: begin
                if (tmr_done) begin
                    if (!acc_store) begin
                        ls_rdata_nxt = mem_rdata_i;
                    end
                    ls_rvalid_nxt = 1'b1;
                    state_nxt     = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk_cpu_n or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ARB_IDLE;
            acc_store   <= 1'b0;
            if_gnt_o    <= 1'b0;
            ls_gnt_o    <= 1'b0;
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state       <= state_nxt;
            acc_store   <= acc_store_nxt;
            if_gnt_o    <= if_gnt_nxt;
            ls_gnt_o    <= ls_gnt_nxt;
            if_rvalid_o <= if_rvalid_nxt;
            ls_rvalid_o <= ls_rvalid_nxt;
            if_rdata_o  <= if_rdata_nxt;
            ls_rdata_o  <= ls_rdata_nxt;
            mem_en_o    <= mem_en_nxt;
            mem_we_o    <= mem_we_nxt;
            mem_addr_o  <= mem_addr_nxt;
            mem_wdata_o <= mem_wdata_nxt;
        end
    end

    assign busy_o = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a response scoreboard
// and a small byte-writable memory model behind the memory port.
module tb_mem_port_arbiter;

    localparam int WAIT_CYC   = 2;
    localparam int STARVE_MAX = 4;

    logic        clk_cpu_n = 1'b0;
    logic        rst_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i, ls_we_i;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_addr_i, ls_wdata_i;
    logic        ls_gnt_o, ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    bit init_done = 1'b0;

    typedef struct {
        bit          is_ls;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    always #5 clk_cpu_n = ~clk_cpu_n;

    mem_port_arbiter #(.WAIT_CYC(WAIT_CYC), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_cpu_n   (clk_cpu_n),
        .rst_n_i     (rst_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_be_i     (ls_be_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    assign mem_rdata_i = mem[mem_addr_o[9:2]];

    // Memory model: preload while init_done is low, then apply byte-enabled stores.
    always @(posedge clk_cpu_n) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A5A0000 | 32'(i);
            mem[8'h40] <= 32'hDEADBEEF;
            mem[8'h80] <= 32'h0BADF00D;
            mem[8'hC0] <= 32'hCAFEF00D;
        end else if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe is exactly the grant cycle, and never granted to both at once.
    always @(negedge clk_cpu_n) begin
        if (checking && rst_n_i)
            chk("strobe_vs_gnt", 32'({mem_en_o, if_gnt_o & ls_gnt_o}), 32'({if_gnt_o | ls_gnt_o, 1'b0}));
    end

    task automatic wait_grant(input bit exp_ls, input string tag, output int waited);
        waited = 0;
        do begin
            @(negedge clk_cpu_n);
            waited++;
        end while (!(if_gnt_o || ls_gnt_o) && waited < 40);
        chk({tag, "_gnt_seen"}, 32'(if_gnt_o | ls_gnt_o), 32'd1);
        chk({tag, "_gnt_owner"}, 32'(ls_gnt_o), 32'(exp_ls));
    endtask

    task automatic wait_rvalid(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_we);
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(negedge clk_cpu_n);
            lat++;
            chk({tag, "_acc_hold"}, {mem_addr_o[27:0], mem_we_o}, {exp_addr[27:0], exp_we});
            chk({tag, "_acc_gnt_low"}, 32'({if_gnt_o, ls_gnt_o, mem_en_o}), 32'd0);
        end while (!(if_rvalid_o || ls_rvalid_o) && lat < 40);
        chk({tag, "_latency"}, 32'(lat), 32'(WAIT_CYC));
        chk({tag, "_one_rvalid"}, 32'(if_rvalid_o & ls_rvalid_o), 32'd0);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rv_owner"}, 32'(ls_rvalid_o), 32'(e.is_ls));
            chk({tag, "_rdata"}, e.is_ls ? ls_rdata_o : if_rdata_o, e.data);
        end
    endtask

    initial begin
        int w;
        bit exp_ls;
        rst_n_i    = 1'b0;
        if_req_i   = 1'b1;
        ls_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0100;
        ls_addr_i  = 32'h0000_0200;
        ls_we_i    = 1'b0;
        ls_be_i    = 4'b1111;
        ls_wdata_i = 32'h0;

        // Reset with both requests high.
        repeat (3) @(negedge clk_cpu_n);
        chk("rst_ctrl", 32'({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_en_o, busy_o}), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_ls_rdata", ls_rdata_o, 32'd0);
        if_req_i  = 1'b0;
        ls_req_i  = 1'b0;
        init_done = 1'b1;
        @(negedge clk_cpu_n);
        rst_n_i  = 1'b1;
        checking = 1'b1;
        @(negedge clk_cpu_n);

        // IF read of 0x100.
        if_addr_i = 32'h0000_0100;
        if_req_i  = 1'b1;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        wait_grant(1'b0, "t2", w);
        chk("t2_addr", mem_addr_o, 32'h100);
        chk("t2_we", 32'(mem_we_o), 32'd0);
        chk("t2_busy", 32'(busy_o), 32'd1);
        if_req_i = 1'b0;
        wait_rvalid("t2", 32'h100, 4'b0000);
        @(negedge clk_cpu_n);
        chk("t2_rvalid_pulse", 32'(if_rvalid_o), 32'd0);
        chk("t2_rdata_hold", if_rdata_o, 32'hDEADBEEF);
        chk("t2_idle", 32'(busy_o), 32'd0);

        // Simultaneous IF + LS load: LS first, IF on the edge after ls_rvalid.
        ls_addr_i = 32'h0000_0200;
        ls_we_i   = 1'b0;
        ls_req_i  = 1'b1;
        if_addr_i = 32'h0000_0104;
        if_req_i  = 1'b1;
        sb.push_back('{1'b1, 32'h0BADF00D});
        sb.push_back('{1'b0, 32'h5A5A0041});
        wait_grant(1'b1, "t3_ls", w);
        ls_req_i = 1'b0;
        wait_rvalid("t3_ls", 32'h200, 4'b0000);
        chk("t3_if_held_off", 32'(if_gnt_o), 32'd0);
        wait_grant(1'b0, "t3_if", w);
        chk("t3_if_gnt_delay", 32'(w), 32'd1);
        if_req_i = 1'b0;
        wait_rvalid("t3_if", 32'h104, 4'b0000);

        // LS store of 0x1234 to 0x300 with be=0011, then read back.
        ls_addr_i  = 32'h0000_0300;
        ls_we_i    = 1'b1;
        ls_be_i    = 4'b0011;
        ls_wdata_i = 32'h0000_1234;
        ls_req_i   = 1'b1;
        sb.push_back('{1'b1, 32'h0BADF00D});
        wait_grant(1'b1, "t4", w);
        chk("t4_we", 32'(mem_we_o), 32'h3);
        chk("t4_wdata", mem_wdata_o, 32'h1234);
        ls_req_i = 1'b0;
        wait_rvalid("t4", 32'h300, 4'b0011);
        ls_we_i  = 1'b0;
        ls_req_i = 1'b1;
        sb.push_back('{1'b1, 32'hCAFE1234});
        wait_grant(1'b1, "t4_rb", w);
        ls_req_i = 1'b0;
        wait_rvalid("t4_rb", 32'h300, 4'b0000);

        // Both requests held: starvation guard decides the fifth grant.
        ls_addr_i = 32'h0000_0200;
        ls_we_i   = 1'b0;
        ls_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        if_req_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_ls = (i < STARVE_MAX);
`else
            exp_ls = 1'b1;
`endif
            sb.push_back('{exp_ls, exp_ls ? 32'h0BADF00D : 32'hDEADBEEF});
            wait_grant(exp_ls, $sformatf("t5_g%0d", i), w);
            if (i > 0) chk($sformatf("t5_g%0d_b2b", i), 32'(w), 32'd1);
            if (i == 4) begin
                ls_req_i = 1'b0;
                if_req_i = 1'b0;
            end
            wait_rvalid($sformatf("t5_g%0d", i), exp_ls ? 32'h200 : 32'h100, 4'b0000);
        end

        // Reset during an LS access: strobe clears at once, no rvalid.
        ls_req_i = 1'b1;
        wait_grant(1'b1, "t6", w);
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_now", 32'({mem_en_o, ls_gnt_o, busy_o}), 32'd0);
        ls_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_cpu_n);
            chk("t6_no_rvalid", 32'({ls_rvalid_o, if_rvalid_o}), 32'd0);
        end
        chk("t6_rdata_rst", ls_rdata_o, 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_cpu_n);
        chk("t6_idle_after", 32'({busy_o, ls_rvalid_o}), 32'd0);
        if_addr_i = 32'h0000_0100;
        if_req_i  = 1'b1;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        wait_grant(1'b0, "t6_fresh", w);
        if_req_i = 1'b0;
        wait_rvalid("t6_fresh", 32'h100, 4'b0000);

        @(negedge clk_cpu_n);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
